matrix_store_module: RTL and testbench



---
 rtl/matrix_store_pkg.sv | 28 ++
 rtl/eight_bit_register_module.sv | 31 +++
 rtl/matrix_store_module.sv | 109 ++++++++++
 tb/tb_matrix_store_module.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/matrix_store_pkg.sv
// matrix_store_pkg
//   Shared constants and element-ordering helpers for the 4x4 matrix
//   store and the matrix element selector. Both blocks use the helpers
//   below, so they agree on which fill index each element has.
package matrix_store_pkg;

    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned DIM      = 4;
    localparam int unsigned NUM_ELEM = DIM * DIM;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Fill index for a zero-based (row, column) pair; fill order is row-major.
    function automatic logic [3:0] elem_index(input logic [1:0] row0,
                                              input logic [1:0] col0);
        return {row0, col0};
    endfunction

    // Selector-side address of fill index k: column in [3:2], row in [1:0].
    function automatic logic [3:0] sel_addr(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage

// File: rtl/eight_bit_register_module.sv
// eight_bit_register_module
//   Element storage register with synchronous reset and load enable.
//   Ports:
//     clk      - rising-edge clock
//     i_reset  - synchronous active-high reset, clears the register to 0
//     i_load   - load i_d on the next rising edge
//     i_d      - data in
//     o_q      - registered data out
module eight_bit_register_module #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/matrix_store_module.sv
// matrix_store_module
//   Loads a 4x4 matrix of 8-bit elements, one element per accepted cycle
//   of a valid/ready stream, in row-major order. When all sixteen are
//   written the matrix is held with out_valid until out_ack.
//   Ports:
//     clk, reset       - clock, synchronous active-high reset
//     clear            - synchronous abort, same effect as reset
//     in_valid/in_data - element stream input
//     in_ready         - high while filling (decoded from state only)
//     out_valid        - complete matrix is held on a11..a44
//     out_ack          - consumer has taken the matrix (used only when full)
//     count            - elements written in the current fill, 0..16
//     a11..a44         - registered matrix elements
module matrix_store_module
    import matrix_store_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [CNT_W-1:0]  count,
    output logic [ELEM_W-1:0] a11, a12, a13, a14,
    output logic [ELEM_W-1:0] a21, a22, a23, a24,
    output logic [ELEM_W-1:0] a31, a32, a33, a34,
    output logic [ELEM_W-1:0] a41, a42, a43, a44
);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_next_count;
    logic              w_fill;
    logic              w_accept;
    logic              w_ack;
    logic              w_elem_reset;
    logic [ELEM_W-1:0] w_q [NUM_ELEM];

    assign w_fill       = (r_state == FILL);
    assign w_accept     = in_valid && w_fill;
    assign w_ack        = (r_state == FULL) && out_ack;
    assign w_elem_reset = reset || clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        if (clear) begin
            w_next_state = FILL;
            w_next_count = '0;
        end else if (w_ack) begin
            w_next_state = FILL;
            w_next_count = '0;
        end else if (w_accept) begin
            w_next_count = r_count + CNT_W'(1);
            if (r_count == CNT_W'(NUM_ELEM - 1)) begin
                w_next_state = FULL;
            end
        end
    end

    // Only the element addressed by the current count loads; a write that
    // coincides with clear is dropped because clear also zeroes the element.
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
        eight_bit_register_module #(
            .W(ELEM_W)
        ) u_reg (
            .clk     (clk),
            .i_reset (w_elem_reset),
            .i_load  (w_accept && (r_count == CNT_W'(k)) && !clear),
            .i_d     (in_data),
            .o_q     (w_q[k])
        );
    end

    assign in_ready  = w_fill;
    assign out_valid = !w_fill;
    assign count     = r_count;

    assign a11 = w_q[elem_index(2'd0, 2'd0)];
    assign a12 = w_q[elem_index(2'd0, 2'd1)];
    assign a13 = w_q[elem_index(2'd0, 2'd2)];
    assign a14 = w_q[elem_index(2'd0, 2'd3)];
    assign a21 = w_q[elem_index(2'd1, 2'd0)];
    assign a22 = w_q[elem_index(2'd1, 2'd1)];
    assign a23 = w_q[elem_index(2'd1, 2'd2)];
    assign a24 = w_q[elem_index(2'd1, 2'd3)];
    assign a31 = w_q[elem_index(2'd2, 2'd0)];
    assign a32 = w_q[elem_index(2'd2, 2'd1)];
    assign a33 = w_q[elem_index(2'd2, 2'd2)];
    assign a34 = w_q[elem_index(2'd2, 2'd3)];
    assign a41 = w_q[elem_index(2'd3, 2'd0)];
    assign a42 = w_q[elem_index(2'd3, 2'd1)];
    assign a43 = w_q[elem_index(2'd3, 2'd2)];
    assign a44 = w_q[elem_index(2'd3, 2'd3)];

endmodule

// File: tb/tb_matrix_store_module.sv
// tb_matrix_store_module
//   Directed plus randomized bench for matrix_store_module. A behavioural
//   model (array of 16 bytes, fill count, full flag) is stepped once per
//   clock alongside the DUT and all outputs are compared after each edge.
module tb_matrix_store_module;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid, out_ack;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [4:0] count;
    logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;

    always #5 clk = ~clk;

    matrix_store_module dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ack(out_ack), .count(count),
        .a11(a11), .a12(a12), .a13(a13), .a14(a14),
        .a21(a21), .a22(a22), .a23(a23), .a24(a24),
        .a31(a31), .a32(a32), .a33(a33), .a34(a34),
        .a41(a41), .a42(a42), .a43(a43), .a44(a44)
    );

    logic [7:0] dut_el [16];
    always_comb dut_el = '{a11, a12, a13, a14, a21, a22, a23, a24,
                           a31, a32, a33, a34, a41, a42, a43, a44};

    // Reference model
    logic [7:0] m_el [16];
    int         m_cnt;
    bit         m_full;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc_no = 0;
    int         first_acc [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_dut();
        logic [127:0] v = '0;
        for (int unsigned i = 0; i < 16; i++) v = {v[119:0], dut_el[i]};
        return v;
    endfunction

    function automatic logic [127:0] pack_model();
        logic [127:0] v = '0;
        for (int unsigned i = 0; i < 16; i++) v = {v[119:0], m_el[i]};
        return v;
    endfunction

    task automatic model_zero();
        for (int unsigned i = 0; i < 16; i++) m_el[i] = 8'h00;
        m_cnt  = 0;
        m_full = 0;
    endtask

    task automatic check_all();
        check("count", 128'(count), 128'(m_cnt));
        check("out_valid", 128'(out_valid), 128'(m_full));
        check("in_ready", 128'(in_ready), 128'(!m_full));
        check("matrix", pack_dut(), pack_model());
    endtask

    // One clock: drive inputs, advance the model by the same rules, compare.
    task automatic step(input bit v, input logic [7:0] d, input bit ack, input bit clr);
        in_valid = v; in_data = d; out_ack = ack; clear = clr;
        @(posedge clk);
        cyc_no++;
        if (clr) begin
            model_zero();
        end else if (m_full) begin
            if (ack) begin
                m_full = 0;
                m_cnt  = 0;
            end
        end else if (v) begin
            if (m_cnt == 0) first_acc.push_back(cyc_no);
            m_el[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 16) m_full = 1;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'($urandom); in_data = 8'($urandom);
        out_ack = 1'($urandom); clear = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_zero();
        check_all();
    endtask

    int ov_cycles;
    logic [7:0] sel_obs, sel_exp;

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ack = 1'b0; in_data = 8'h00;
        model_zero();
        do_reset();

        // Stream 01..10 back to back
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("a11", 128'(a11), 128'(8'h01));
        check("a14", 128'(a14), 128'(8'h04));
        check("a21", 128'(a21), 128'(8'h05));
        check("a44", 128'(a44), 128'(8'h10));
        check("full_count", 128'(count), 128'(5'd16));
        check("full_valid", 128'(out_valid), 128'(1'b1));

        // Hold FULL while pushing 8'hFF, then acknowledge
        for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("ack_count", 128'(count), 128'(5'd0));
        check("ack_ready", 128'(in_ready), 128'(1'b1));

        // Partial fill with a gap, 7th element to a23
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        check("gap_count", 128'(count), 128'(5'd6));
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("a23", 128'(a23), 128'(8'hAA));

        // Reach 9 elements, then clear together with a write
        for (int i = 0; i < 2; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("pre_clear_count", 128'(count), 128'(5'd9));
        step(1'b1, 8'h5A, 1'b0, 1'b1);
        check("clear_count", 128'(count), 128'(5'd0));
        check("clear_matrix", pack_dut(), 128'(0));

        // Random full matrix, then selector-style read-back
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int unsigned s = 0; s < 16; s++) begin
            logic [3:0] s0;
            s0 = 4'(s);
            // Selector: row from s0[1:0], column from s0[3:2]
            sel_obs = dut_el[int'(s0[1:0]) * 4 + int'(s0[3:2])];
            sel_exp = m_el[int'({s0[1:0], s0[3:2]})];
            check("selector", 128'(sel_obs), 128'(sel_exp));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Two matrices back to back with out_ack tied high
        do_reset();
        first_acc.delete();
        ov_cycles = 0;
        for (int i = 0; i < 34; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (out_valid) ov_cycles++;
        end
        check("b2b_valid_cycles", 128'(ov_cycles), 128'(2));
        check("b2b_starts", 128'(first_acc.size()), 128'(2));
        if (first_acc.size() == 2)
            check("b2b_period", 128'(first_acc[1] - first_acc[0]), 128'(17));

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(($urandom_range(3) != 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(31) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
